// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier that stalls the pipeline for RV32 mul.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             w_load;
  logic             w_last;
  assign w_load = (r_state == S_IDLE) && start_i && !abort_i;
`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (abort_i) begin
      r_state <= S_IDLE;
    end else if (w_load) begin
      r_mcand  <= rs1_i;
      r_mplier <= rs2_i;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_state  <= S_RUN;
    end else if (r_state == S_RUN) begin
      r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      r_state  <= w_last ? S_DONE : S_RUN;
    end else begin
      r_state <= S_IDLE;
    end
  end
  // Stall is gated by reset so a held start cannot freeze the pipeline during reset.
  assign stall_o  = rst_i && (w_load || r_state == S_RUN);
  assign busy_o   = (r_state == S_RUN);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_acc;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: table vectors, directed abort/reset/back-to-back sequences and random ops.
module tb_mul_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b1;
  logic        abort_i = 1'b0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  int n_cmp = 0;
  int n_bad = 0;
  int gcyc = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  vec_t tv[7];

  mul_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_o(stall_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) gcyc <= gcyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h + 2;
`else
    return 33;
`endif
  endfunction

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        output int done_at);
    int  cyc = 0;
    bit  got = 0;
    rs1_i = a; rs2_i = b; start_i = 1'b1; abort_i = 1'b0;
    done_at = -1;
    while (!got && cyc <= 100) begin
      @(negedge clk_i);
      if (done_o) begin
        got = 1;
      end else begin
        chk("stall_run", 32'(stall_o), 32'd1);
        chk("busy_run", 32'(busy_o), 32'(cyc != 0));
        cyc++;
        @(posedge clk_i); #1;
        rs1_i = $urandom; rs2_i = $urandom;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no done_o within 100 cycles for %h*%h", a, b);
    end else begin
      done_at = gcyc;
      chk("latency", 32'(cyc), 32'(model_lat(b)));
      chk("stall_done", 32'(stall_o), 32'd0);
      chk("busy_done", 32'(busy_o), 32'd0);
      chk("result", result_o, exp);
    end
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  initial begin
    int d0, d1;
    tv[0] = '{32'd7, 32'd6, 32'd42};
    tv[1] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB};
    tv[2] = '{32'h8000_0000, 32'd2, 32'h0};
    tv[3] = '{32'd9, 32'd9, 32'd81};
    tv[4] = '{32'd123, 32'd0, 32'd0};
    tv[5] = '{32'd123, 32'h100, 32'd31488};
    tv[6] = '{32'd123, 32'd1, 32'd123};
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 7; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].r, d0);
      @(negedge clk_i);
      chk("hold_result", result_o, tv[i].r);
      chk("hold_done", 32'(done_o), 32'd0);
      chk("hold_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
    end
    run_op(32'd3, 32'd4, 32'd12, d0);
    run_op(32'h1_0000, 32'h1_0000, 32'd0, d1);
    chk("b2b_spacing", 32'(d1 - d0), 32'(model_lat(32'h1_0000) + 1));
    start_i = 1'b1; rs1_i = 32'd5; rs2_i = 32'hFFFF_FFFF;
    repeat (10) @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(negedge clk_i);
    chk("abort_stall_c10", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    @(posedge clk_i); #1;
    run_op(32'd6, 32'd7, 32'd42, d0);
    start_i = 1'b1; abort_i = 1'b1; rs1_i = 32'd2; rs2_i = 32'd3;
    @(negedge clk_i);
    chk("start_abort_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    @(negedge clk_i);
    chk("start_abort_busy", 32'(busy_o), 32'd0);
    chk("start_abort_noload", result_o, 32'd42);
    @(posedge clk_i); #1;
    start_i = 1'b1; rs1_i = 32'hFFFF; rs2_i = 32'hFFFF;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("mrst_stall", 32'(stall_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_done", 32'(done_o), 32'd0);
    chk("mrst_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    run_op(32'd9, 32'd9, 32'd81, d0);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b, p;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      p = a * b;
      run_op(a, b, p, d0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiplier sequencer for the EX stage. When the ALU control decode selects `mul`, it freezes the pipeline while it iterates over the multiplier bits, then returns the low WIDTH bits of the product with a one-cycle done pulse. All other ALU operations bypass it unaffected. It sits beside the ALU. Its stall feeds the hazard logic that holds PC, IF/ID, ID/EX and EX/MEM.

## Interface
- WIDTH, 32, operand and result width in bits (≥2)
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous reset, active-low
- start_i  input  1  EX instruction is `mul`. Held high by the frozen pipeline for the whole operation.
- abort_i  input  1  synchronous cancel of the in-flight operation
- rs1_i  input  WIDTH  multiplicand, sampled on start
- rs2_i  input  WIDTH  multiplier, sampled on start
- stall_o  output  1  freeze pipeline (combinational, see Operation)
- busy_o  output  1  state is RUN
- done_o  output  1  one-cycle pulse; result_o valid
- result_o  output  WIDTH  low WIDTH bits of rs1×rs2

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal registers:
  - mcand, WIDTH bits
  - mplier, WIDTH bits
  - acc, WIDTH bits, drives result_o
  - cnt, clog2(WIDTH) bits
- IDLE:
  - If start_i=1 and abort_i=0: mcand←rs1_i, mplier←rs2_i, acc←0, cnt←0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If mplier[0]=1: acc←acc+mcand, truncated to WIDTH.
  - mcand←mcand<<1, truncated. mplier←mplier>>1, logical. cnt←cnt+1.
  - If cnt==WIDTH−1: go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then go to IDLE unconditionally.
  - start_i seen in DONE is the same instruction and is ignored.
- abort_i=1 in any state: go to IDLE next edge, with no done pulse. acc is left as is.
- start_i while RUN or DONE does not reload the operands.
- Truncated arithmetic makes the result identical for signed and unsigned operands (RV32 `mul` semantics).
- stall_o = (state==IDLE ∧ start_i ∧ ¬abort_i) ∨ state==RUN. It is forced to 0 while rst_i=0.
- busy_o = (state==RUN).
- result_o = acc. It holds its value after DONE until the next load.

## Timing
- Reset values: stall_o=0, busy_o=0, done_o=0, result_o=0, state=IDLE, all internal registers 0.
- Let cycle 0 be the first cycle with start_i=1 in IDLE.
- stall_o is high in cycles 0..WIDTH. done_o is high in cycle WIDTH+1, with stall_o=0 so the pipeline advances on that edge.
- Total latency is WIDTH+1 cycles.
- Back-to-back `mul`: the next instruction reaches EX in cycle WIDTH+2 and finds the block in IDLE. Its cycle 0 is WIDTH+2.
- Async reset mid-RUN: all outputs drop to reset values immediately. The operation is lost with no done pulse.
- abort_i and start_i in the same IDLE cycle: abort wins. No load, stall_o=0.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - In RUN, also go to DONE when the post-shift mplier (mplier>>1) is 0.
  - Latency becomes (index of the highest set bit of rs2)+2 cycles.
  - rs2=0 or rs2=1 gives done_o in cycle 2.
- MUL_EARLY_EXIT_EN undefined: fixed WIDTH-cycle RUN, as specified above.
- Results are identical either way.

## Test plan
- Basic: rs1=7, rs2=6, start held, macro off, WIDTH=32 -> stall_o high in cycles 0–32, done_o in cycle 33, result_o=42.
- Wrap/sign: rs1=0xFFFFFFFF (−1), rs2=5 -> result_o=0xFFFFFFFB. Also 0x80000000×2 -> 0x00000000.
- Back-to-back: two `mul` in consecutive EX slots (3×4, then 0x10000×0x10000) -> two done pulses 34 cycles apart, results 12 and 0, no reload during DONE.
- Abort: start at cycle 0, abort_i at cycle 10 -> IDLE at cycle 11, stall_o=0, no done_o. A new start at cycle 12 completes normally.
- Reset mid-op: rst_i low at cycle 5 -> outputs 0 within the same cycle. After release, 9×9 gives 81.
- MUL_EARLY_EXIT_EN: rs1=123, rs2=0 -> done_o in cycle 2, result 0. rs2=0x00000100 -> done_o in cycle 10, result 31488.
